// File: rtl/dsp_add_arbiter_if.sv
// Request/response bundle between the two requesters and the shared-adder arbiter.
// The arbiter takes the slave view; the requesters (or a bench) take the master view.
interface dsp_add_arbiter_if;
    logic        r0_valid;
    logic        r0_ready;
    logic [31:0] r0_a;
    logic [31:0] r0_b;
    logic        r1_valid;
    logic        r1_ready;
    logic [31:0] r1_a;
    logic [31:0] r1_b;
    logic        resp0_valid;
    logic        resp0_ready;
    logic        resp1_valid;
    logic        resp1_ready;
    logic [31:0] resp_sum;
    logic        busy;

    modport master (
        output r0_valid, r0_a, r0_b, r1_valid, r1_a, r1_b, resp0_ready, resp1_ready,
        input  r0_ready, r1_ready, resp0_valid, resp1_valid, resp_sum, busy
    );

    modport slave (
        input  r0_valid, r0_a, r0_b, r1_valid, r1_a, r1_b, resp0_ready, resp1_ready,
        output r0_ready, r1_ready, resp0_valid, resp1_valid, resp_sum, busy
    );
endinterface

// File: rtl/dsp_add_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit DSP adder between two requesters.
// One operation in flight: IDLE (grant) -> CALC (operands registered) -> RESP (sum registered).

// The DSP adds in two 16-bit halves; the low-half carry feeds the high half.
module adder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic [31:0] sum_o
);
    logic [16:0] lo;
    logic [15:0] hi;

    assign lo    = {1'b0, a_i[15:0]} + {1'b0, b_i[15:0]};
    assign hi    = a_i[31:16] + b_i[31:16] + {15'b0, lo[16]};
    assign sum_o = {hi, lo[15:0]};
endmodule

module dsp_add_arbiter #(
    parameter bit PRIO_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    dsp_add_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } state_e;

    state_e      state_q;
    logic [31:0] op_a_q;
    logic [31:0] op_b_q;
    logic [31:0] resp_sum_q;
    logic [31:0] sum_d;
    logic        owner_q;
    logic        last_grant_q;
    logic        grant0;
    logic        grant1;

    // A lone requester always wins; on a tie the one not granted last time wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state_q == IDLE) begin
            grant0 = bus.r0_valid && (!bus.r1_valid || last_grant_q != 1'b0);
            grant1 = bus.r1_valid && (!bus.r0_valid || last_grant_q != 1'b1);
        end
    end

    adder u_adder (
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .sum_o (sum_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            op_a_q       <= 32'd0;
            op_b_q       <= 32'd0;
            owner_q      <= 1'b0;
            resp_sum_q   <= 32'd0;
            last_grant_q <= ~PRIO_FIRST;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0) begin
                        op_a_q       <= bus.r0_a;
                        op_b_q       <= bus.r0_b;
                        owner_q      <= 1'b0;
                        last_grant_q <= 1'b0;
                        state_q      <= CALC;
                    end else if (grant1) begin
                        op_a_q       <= bus.r1_a;
                        op_b_q       <= bus.r1_b;
                        owner_q      <= 1'b1;
                        last_grant_q <= 1'b1;
                        state_q      <= CALC;
                    end
                end
                CALC: begin
                    resp_sum_q <= sum_d;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (owner_q ? bus.resp1_ready : bus.resp0_ready) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.r0_ready    = grant0;
    assign bus.r1_ready    = grant1;
    assign bus.resp0_valid = (state_q == RESP) && !owner_q;
    assign bus.resp1_valid = (state_q == RESP) && owner_q;
    assign bus.resp_sum    = resp_sum_q;
    assign bus.busy        = (state_q != IDLE);
endmodule
